// File: rtl/tc_sram_banked_if.sv
// Request/response channel bundle for the banked SRAM wrapper.
// Signal names keep the macro's port naming so the bus reads like the datasheet.
interface tc_sram_banked_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_wren_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [DATA_W/8-1:0] req_mask_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;

  modport master (
    output req_valid_i, req_wren_i, req_addr_i,
    output req_wdata_i, req_mask_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_wren_i, req_addr_i,
    input  req_wdata_i, req_mask_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/tc_sram_banked.sv
// Multi-bank byte-maskable single-port SRAM wrapper with
// credit-gated requests and an in-order response FIFO.
module tc_sram_banked #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int BANKS   = 4,
  parameter int OUT_REG = 1
) (
  input logic             clk_i,
  input logic             rst_n_i,
  tc_sram_banked_if.slave bus
);
  localparam int NB   = DATA_W / 8;
  localparam int BB   = $clog2(BANKS);
  localparam int BW   = (BB > 0) ? BB : 1;
  localparam int RW   = ADDR_W - BB;
  localparam int ROWS = 2 ** RW;
  localparam int LAT  = 1 + OUT_REG;
  localparam int CRED = LAT + 1;
  localparam int CW   = $clog2(CRED + 1);
  localparam int PW   = $clog2(CRED);

  logic              acc;
  logic              rd_acc;
  logic              pop;
  logic              push;
  logic [BW-1:0]     bank;
  logic [RW-1:0]     row;
  logic [CW-1:0]     cnt;
  logic              s1_v;
  logic [BW-1:0]     s1_bank;
  logic [DATA_W-1:0] rd_all [BANKS];
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] fifo [CRED];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     fcnt;
  logic [DATA_W-1:0] last_q;

  assign bus.req_ready_o = (cnt < CW'(CRED));
  assign acc    = bus.req_valid_i & bus.req_ready_o;
  assign rd_acc = acc & ~bus.req_wren_i;
  assign row    = bus.req_addr_i[ADDR_W-1:BB];

  if (BB > 0) begin : g_bsel
    assign bank = bus.req_addr_i[BW-1:0];
  end else begin : g_bone
    assign bank = 1'b0;
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] dout;
    logic              cs;

    assign cs        = acc && (bank == BW'(g));
    assign rd_all[g] = dout;

    always_ff @(posedge clk_i) begin
      if (cs && bus.req_wren_i) begin
        for (int b = 0; b < NB; b++)
          if (bus.req_mask_i[b])
            mem[row][8*b +: 8] <= bus.req_wdata_i[8*b +: 8];
      end else if (cs) begin
        dout <= mem[row];
      end
    end
  end

  assign s1_data = rd_all[s1_bank];

  if (OUT_REG != 0) begin : g_oreg
    logic              s2_v;
    logic [DATA_W-1:0] s2_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s2_v    <= 1'b0;
        s2_data <= '0;
      end else begin
        s2_v <= s1_v;
        if (s1_v) s2_data <= s1_data;
      end
    end

    assign push      = s2_v;
    assign push_data = s2_data;
  end else begin : g_noreg
    assign push      = s1_v;
    assign push_data = s1_data;
  end

  // Data shows the head while valid, else the last popped word.
  assign bus.rsp_valid_o = (fcnt != '0);
  assign pop             = bus.rsp_valid_o & bus.rsp_ready_i;
  assign bus.rsp_rdata_o = bus.rsp_valid_o ? fifo[rp] : last_q;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(CRED - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) fifo[wp] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt     <= '0;
      s1_v    <= 1'b0;
      s1_bank <= '0;
      wp      <= '0;
      rp      <= '0;
      fcnt    <= '0;
      last_q  <= '0;
    end else begin
      s1_v <= rd_acc;
      if (rd_acc) s1_bank <= bank;
      if (rd_acc != pop)
        cnt <= rd_acc ? cnt + 1'b1 : cnt - 1'b1;
      if (push) wp <= inc(wp);
      if (pop) begin
        rp     <= inc(rp);
        last_q <= fifo[rp];
      end
      if (push != pop)
        fcnt <= push ? fcnt + 1'b1 : fcnt - 1'b1;
      assert (!(push && !pop && fcnt == CW'(CRED)));
      assert (!(pop && fcnt == '0));
    end
  end
endmodule
